// File: rtl/wvb_rdout_arb.sv
// Round-robin read-out arbiter granting the shared waveform reader to one channel.
// Full header FIFOs win over merely non-empty ones; a watchdog reclaims stuck grants.
module wvb_rdout_arb #(
  parameter int N_CHANNELS = 14,
  parameter int P_TIMEOUT  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_CHANNELS-1:0] chan_mask,
  input  logic [N_CHANNELS-1:0] hdr_empty,
  input  logic [N_CHANNELS-1:0] hdr_full,
  input  logic                  rd_done,
  input  logic                  timeout_clr,
  output logic                  grant_valid,
  output logic [N_CHANNELS-1:0] grant,
  output logic [3:0]            grant_idx,
  output logic                  busy,
  output logic                  timeout_flag,
  output logic [3:0]            timeout_chan,
  output logic [31:0]           grant_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_REL
  } state_t;

  localparam bit          WD_ON   = (P_TIMEOUT != 0);
  localparam logic [15:0] WD_LAST =
    16'(P_TIMEOUT == 0 ? 0 : P_TIMEOUT - 1);
  localparam logic [4:0]  NC5     = 5'(N_CHANNELS);
  localparam logic [3:0]  LAST    = 4'(N_CHANNELS - 1);

  state_t state;
  logic [3:0]  ptr;
  logic [15:0] wd;

  logic [N_CHANNELS-1:0] elig;
  logic [N_CHANNELS-1:0] prio;
  logic [N_CHANNELS-1:0] pick_vec;
  logic [N_CHANNELS-1:0] onehot;
  logic [31:0] pv;
  logic [4:0]  j;
  logic [3:0]  cand;
  logic [3:0]  nptr;
  logic        cand_ok;

  assign elig     = chan_mask & ~hdr_empty;
  assign prio     = elig & hdr_full;
  assign pick_vec = (|prio) ? prio : elig;
  assign pv       = 32'(pick_vec);

  // Scan from ptr upward, wrapping at N_CHANNELS; first hit wins.
  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    j       = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      j = {1'b0, ptr} + 5'(k);
      if (j >= NC5) j = j - NC5;
      if (!cand_ok && pv[j]) begin
        cand_ok = 1'b1;
        cand    = j[3:0];
      end
    end
  end

  assign nptr   = (cand == LAST) ? 4'd0 : cand + 4'd1;
  assign onehot = N_CHANNELS'(32'd1 << cand);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      wd           <= '0;
      grant_valid  <= 1'b0;
      grant        <= '0;
      grant_idx    <= '0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
      timeout_chan <= '0;
      grant_count  <= '0;
    end else begin
      if (timeout_clr) timeout_flag <= 1'b0;
      unique case (state)
        S_IDLE: begin
          wd <= '0;
          if (en && cand_ok) begin
            state       <= S_GRANT;
            grant       <= onehot;
            grant_idx   <= cand;
            grant_valid <= 1'b1;
            busy        <= 1'b1;
            ptr         <= nptr;
            grant_count <= grant_count + 32'd1;
          end
        end
        S_GRANT: begin
          wd <= wd + 16'd1;
          if (rd_done) begin
            state       <= S_REL;
            grant_valid <= 1'b0;
            grant       <= '0;
          end else if (WD_ON && wd == WD_LAST) begin
            state        <= S_REL;
            grant_valid  <= 1'b0;
            grant        <= '0;
            timeout_flag <= 1'b1;
            timeout_chan <= grant_idx;
          end
        end
        S_REL: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wvb_rdout_arb.sv
// Directed bench for wvb_rdout_arb: a grant-level model checked every cycle,
// plus literal expectations for the arbitration scenarios.
module tb_wvb_rdout_arb;

  localparam int NC = 14;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic [NC-1:0] chan_mask = '1;
  logic [NC-1:0] hdr_empty = '1;
  logic [NC-1:0] hdr_full = '0;
  logic          rd_done = 1'b0;
  logic          timeout_clr = 1'b0;
  logic          grant_valid;
  logic [NC-1:0] grant;
  logic [3:0]    grant_idx;
  logic          busy;
  logic          timeout_flag;
  logic [3:0]    timeout_chan;
  logic [31:0]   grant_count;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  wvb_rdout_arb #(.N_CHANNELS(NC), .P_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en),
    .chan_mask(chan_mask), .hdr_empty(hdr_empty),
    .hdr_full(hdr_full), .rd_done(rd_done),
    .timeout_clr(timeout_clr),
    .grant_valid(grant_valid), .grant(grant),
    .grant_idx(grant_idx), .busy(busy),
    .timeout_flag(timeout_flag),
    .timeout_chan(timeout_chan),
    .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = waiting, 1 = holding a grant, 2 = settle cycle.
  int          m_phase = 0;
  bit          m_gv = 0;
  int          m_idx = 0;
  int          m_ptr = 0;
  int          m_held = 0;
  int unsigned m_count = 0;
  bit          m_flag = 0;
  int          m_tchan = 0;

  function automatic int pick(int p, logic [NC-1:0] e,
                              logic [NC-1:0] f);
    logic [NC-1:0] v;
    int i;
    v = ((e & f) != 0) ? (e & f) : e;
    for (int k = 0; k < NC; k++) begin
      i = (p + k) % NC;
      if (v[i[3:0]]) return i;
    end
    return -1;
  endfunction

  initial forever begin
    logic [NC-1:0] e, mg;
    int c;
    @(negedge clk);
    if (chk_on) begin
      mg = m_gv ? NC'(1 << m_idx) : '0;
      n_cmp++;
      if (grant_valid !== m_gv || grant !== mg ||
          int'(grant_idx) != m_idx ||
          busy !== (m_phase != 0) ||
          timeout_flag !== m_flag ||
          int'(timeout_chan) != m_tchan ||
          grant_count !== m_count) begin
        n_err++;
        $display("FAIL cycle t=%0t gv %b/%b grant %h/%h idx %0d/%0d busy %b/%b tflag %b/%b tchan %0d/%0d cnt %0d/%0d",
          $time, grant_valid, m_gv, grant, mg, grant_idx, m_idx,
          busy, (m_phase != 0), timeout_flag, m_flag,
          timeout_chan, m_tchan, grant_count, m_count);
      end
    end
    if (rst) begin
      m_phase = 0; m_gv = 0; m_idx = 0; m_ptr = 0;
      m_held = 0; m_count = 0; m_flag = 0; m_tchan = 0;
    end else begin
      if (timeout_clr) m_flag = 0;
      case (m_phase)
        0: begin
          e = chan_mask & ~hdr_empty;
          if (en && e != 0) begin
            c = pick(m_ptr, e, hdr_full);
            m_idx = c;
            m_ptr = (c + 1) % NC;
            m_gv = 1;
            m_held = 0;
            m_count++;
            m_phase = 1;
          end
        end
        1: begin
          m_held++;
          if (rd_done) begin
            m_gv = 0; m_phase = 2;
          end else if (m_held == TO) begin
            m_gv = 0; m_phase = 2;
            m_flag = 1; m_tchan = m_idx;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_gv();
    int n = 0;
    while (!grant_valid && n < 40) begin
      tick();
      n++;
    end
    chk("wait_grant", longint'(grant_valid), 1);
  endtask

  task automatic pulse_done();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  function automatic logic [NC-1:0] bits(int a, int b, int c);
    logic [NC-1:0] v = '0;
    if (a >= 0) v[a[3:0]] = 1'b1;
    if (b >= 0) v[b[3:0]] = 1'b1;
    if (c >= 0) v[c[3:0]] = 1'b1;
    return v;
  endfunction

  int rr_exp[5] = '{2, 5, 13, 2, 5};
  int fp_exp[3] = '{3, 7, 9};

  initial begin
    int n;
    rst = 1'b1;
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_gv", longint'(grant_valid), 0);
    chk("rst_count", longint'(grant_count), 0);
    chk("rst_busy", longint'(busy), 0);

    // Round robin over channels 2, 5, 13
    hdr_empty = ~bits(2, 5, 13);
    for (int i = 0; i < 5; i++) begin
      wait_gv();
      chk("rr_idx", longint'(grant_idx), rr_exp[i]);
      chk("rr_onehot", longint'(grant), longint'(1) << rr_exp[i]);
      if (i == 4) chk("rr_count", longint'(grant_count), 5);
      tick(); tick(); tick();
      pulse_done();
      if (i == 4) en = 1'b0;
    end
    tick(); tick();

    // Full-FIFO priority starting from ptr = 6
    hdr_empty = ~bits(3, 7, 9);
    hdr_full = bits(3, -1, -1);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_gv();
      chk("fp_idx", longint'(grant_idx), fp_exp[i]);
      hdr_full = '0;
      tick(); tick(); tick();
      pulse_done();
      if (i == 2) en = 1'b0;
    end
    tick(); tick();

    // Back-to-back grants with instant completion
    hdr_empty = ~bits(4, -1, -1);
    en = 1'b1;
    wait_gv();
    for (int i = 0; i < 9; i++) begin
      chk("lat_gv", longint'(grant_valid), (i % 3 == 0) ? 1 : 0);
      chk("lat_idx", longint'(grant_idx), 4);
      rd_done = grant_valid;
      tick();
    end
    rd_done = 1'b0;
    en = 1'b0;
    pulse_done();
    tick(); tick();

    // Watchdog expiry, clear colliding with the set
    hdr_empty = ~bits(1, -1, -1);
    en = 1'b1;
    wait_gv();
    n = 0;
    while (grant_valid && n < 20) begin
      if (n == TO - 1) timeout_clr = 1'b1;
      n++;
      tick();
      timeout_clr = 1'b0;
    end
    en = 1'b0;
    chk("wd_len", n, TO);
    chk("wd_flag", longint'(timeout_flag), 1);
    chk("wd_chan", longint'(timeout_chan), 1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    chk("wd_clr", longint'(timeout_flag), 0);
    tick();

    // Completion on the expiry cycle is not a timeout
    en = 1'b1;
    wait_gv();
    for (int i = 0; i < TO - 1; i++) tick();
    pulse_done();
    en = 1'b0;
    chk("wd_done_gv", longint'(grant_valid), 0);
    chk("wd_done_flag", longint'(timeout_flag), 0);
    tick(); tick();

    // Masked channel 5 is never granted; en drop mid-grant
    chan_mask = ~bits(5, -1, -1);
    hdr_empty = ~bits(5, 8, -1);
    en = 1'b1;
    wait_gv();
    chk("mask_idx", longint'(grant_idx), 8);
    en = 1'b0;
    tick(); tick();
    chk("en_hold", longint'(grant_valid), 1);
    pulse_done();
    for (int i = 0; i < 6; i++) begin
      chk("en_off", longint'(grant_valid), 0);
      tick();
    end
    en = 1'b1;
    wait_gv();
    chk("mask_idx2", longint'(grant_idx), 8);
    tick(); tick();
    pulse_done();
    en = 1'b0;
    tick(); tick();
    chan_mask = '1;

    // Reset in the middle of a grant
    hdr_empty = ~bits(3, 11, -1);
    en = 1'b1;
    wait_gv();
    chk("pre_rst_idx", longint'(grant_idx), 11);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_gv", longint'(grant_valid), 0);
    chk("rst_mid_grant", longint'(grant), 0);
    chk("rst_mid_count", longint'(grant_count), 0);
    wait_gv();
    chk("post_rst_idx", longint'(grant_idx), 3);
    chk("post_rst_count", longint'(grant_count), 1);
    tick();
    pulse_done();
    en = 1'b0;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
